wrf_pkt_checker: RTL and testbench
==================================

WRF_PKT_CHECKER -- requirements
Module: wrf_pkt_checker

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk_i, rst_n_i.
REQ-002 SHALL provide these ports, one per line: name  direction  width  meaning.
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous active-low reset
- snk_cyc  in  1  fabric frame envelope
- snk_stb  in  1  fabric strobe
- snk_we  in  1  fabric write, always 1
- snk_sel  in  2  byte selects
- snk_adr  in  2  fabric address: 00 data, 01 OOB, 10 status, 11 user
- snk_dat  in  16  fabric data
- snk_ack  out  1  fabric ack
- snk_stall  out  1  fabric stall
- wb_cyc  in  1  register bus cycle
- wb_stb  in  1  register bus strobe
- wb_we  in  1  register bus write enable
- wb_sel  in  4  register bus byte selects, ignored
- wb_adr  in  32  register bus byte address; bits [4:2] decoded
- wb_dat_i  in  32  register bus write data
- wb_dat_o  out  32  register bus read data
- wb_ack  out  1  register bus ack
- wb_stall  out  1  register bus stall, constant 0

Function
REQ-003 SHALL implement the receiving end of the test-frame format:
- header: 7 data words (dst 3, src 3, length 1)
- payload word 0: 16-bit sequence number
- payload words 1..n: LFSR words
REQ-004 SHALL ack every accepted fabric beat (snk_cyc & snk_stb & ~snk_stall), at any address, exactly one cycle after acceptance; no beat dropped or double-acked.
REQ-005 SHALL hold snk_stall at 0 when WRF_CHK_RAND_STALL_EN is undefined.
REQ-006 SHALL run FSM IDLE -> HDR -> SEQ -> PAYLOAD -> EVAL -> IDLE:
- rising snk_cyc leaves IDLE
- 7th header data word enters SEQ
- the sequence word enters PAYLOAD
- falling snk_cyc from any non-IDLE state enters EVAL
- EVAL lasts one cycle, then IDLE
REQ-007 SHALL consider only adr=00 beats as data; adr 01/10/11 beats are acked but not checked.
REQ-008 SHALL count payload bytes as popcount(snk_sel) per data beat after the header; the sequence word is included in the count.
REQ-009 SHALL use LFSR polynomial x^16+x^14+x^13+x^11+1 (Fibonacci, shift left).
- Seed = seq XOR 0xACE1; a seed of 0 is replaced by 0xACE1.
- Payload word 1 equals the seed; each following word equals next(previous).
- Only selected bytes are compared.
REQ-010 SHALL flag a length error in EVAL if either holds:
- the received payload byte count differs from the header length word
- the frame ended before the sequence word (runt)
REQ-011 SHALL, in EVAL, increment exactly one counter:
- ERR_LEN on a length error (takes priority)
- else ERR_DATA on any payload mismatch
- else OK
REQ-012 SHALL track sequence numbers for every frame that reached PAYLOAD:
- The first frame after enable or clear only sets expected = seq+1.
- Thereafter, if seq ≠ expected, LOST += (seq - expected) mod 2^16.
- expected = seq+1 (mod 2^16) after every such frame.
REQ-013 SHALL make all counters 32-bit and saturating at 0xFFFFFFFF.
REQ-014 SHALL implement this register map (wb_adr[4:2]):
- 0 CTRL: bit0 ENABLE (rw); bit1 CLEAR (write 1, self-clearing)
- 1 OK (ro)
- 2 ERR_LEN (ro)
- 3 ERR_DATA (ro)
- 4 LOST (ro)
- 5 LAST_SEQ (ro, low 16 bits)
- 6-7 read 0
REQ-015 SHALL ack each register access one cycle after strobe; wb_dat_o is valid with wb_ack.
REQ-016 SHALL, while ENABLE=0, keep acking fabric beats but perform no checking and no counter updates; ENABLE changing mid-frame takes effect at the next rising snk_cyc.
REQ-017 SHALL make CLEAR win over a same-cycle EVAL increment.
REQ-018 SHALL, on CLEAR mid-frame, zero all counters, re-arm sequence tracking, and ignore the current frame until the next rising snk_cyc.

Reset
REQ-019 SHALL, with rst_n_i=0 at a clk_i edge:
- zero all counters, LAST_SEQ, CTRL, snk_ack, wb_ack and wb_dat_o
- set the FSM to IDLE and re-arm sequence tracking
- abandon any frame in progress (mid-frame reset)

Configuration
REQ-020 SHALL, with macro WRF_CHK_RAND_STALL_EN defined, drive snk_stall from bit 0 of a free-running 16-bit LFSR (reset seed 0xACE1), so that on average half of all cycles stall.
REQ-021 SHALL, without WRF_CHK_RAND_STALL_EN, contain no stall LFSR and tie snk_stall to 0.

Verification
REQ-022 SHALL cover: ENABLE=1, frames seq 0..9, length 100 -> OK=10, ERR_LEN=ERR_DATA=LOST=0, LAST_SEQ=9.
REQ-023 SHALL cover: frame seq 0 then seq 5 -> LOST=4, OK=2.
REQ-024 SHALL cover: length word 200 with 198 payload bytes -> ERR_LEN=1, OK=0; frame with 3 header words only -> ERR_LEN increments.
REQ-025 SHALL cover: payload word 10 corrupted by XOR 0x0001 -> ERR_DATA=1, OK unchanged.
REQ-026 SHALL cover: CLEAR written mid-frame -> all counters 0; the next frame seq 42 -> OK=1, LOST=0.
REQ-027 SHALL cover: with WRF_CHK_RAND_STALL_EN defined, 1000 frames -> acks equal accepted beats, OK=1000.

Source files
------------

// File: rtl/wrf_pkt_checker_if.sv
// Fabric sink and register bus of the test-frame checker.
// The bench or upstream logic takes the master side and the checker takes the slave side.
interface wrf_pkt_checker_if;
    logic        snk_cyc;
    logic        snk_stb;
    logic        snk_we;
    logic [1:0]  snk_sel;
    logic [1:0]  snk_adr;
    logic [15:0] snk_dat;
    logic        snk_ack;
    logic        snk_stall;

    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        wb_stall;

    modport master (
        output snk_cyc, snk_stb, snk_we, snk_sel, snk_adr, snk_dat,
        input  snk_ack, snk_stall,
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack, wb_stall
    );

    modport slave (
        input  snk_cyc, snk_stb, snk_we, snk_sel, snk_adr, snk_dat,
        output snk_ack, snk_stall,
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack, wb_stall
    );
endinterface

// File: rtl/wrf_pkt_checker.sv
// Test-frame receiver: checks header length, sequence continuity and LFSR payload; counters readable on a register bus.
// Latency: fabric ack and register ack one cycle after acceptance / strobe.
// Backpressure: snk_stall tied 0; WRF_CHK_RAND_STALL_EN drives it from a free-running LFSR.
module wrf_pkt_checker (
    input  logic             clk_i,
    input  logic             rst_n_i,
    wrf_pkt_checker_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_PAYLOAD, S_EVAL} state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [15:0] d);
        logic [32:0] s;
        s = {1'b0, c} + {17'd0, d};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    state_t      state, state_nxt;
    logic        cyc_q;
    logic        rise, fall, accept, data_beat;
    logic        hdr_beat, seq_beat, pl_beat, eval, mism, len_err;
    logic [1:0]  pop;
    logic [15:0] seed;

    logic [2:0]  hdr_cnt;
    logic [15:0] len_q, seq_q, lfsr_q;
    logic [31:0] byte_cnt;
    logic        data_err, reached_pl, frame_en;

    logic        enable, seq_armed;
    logic [15:0] exp_seq, last_seq;
    logic [31:0] cnt_ok, cnt_len, cnt_data, cnt_lost;
    logic        wb_req, wr_ctrl, clr, en_rise;
    logic [31:0] rd_mux;

    assign rise      = bus.snk_cyc & ~cyc_q;
    assign fall      = ~bus.snk_cyc & cyc_q;
    assign accept    = bus.snk_cyc & bus.snk_stb & ~bus.snk_stall;
    assign data_beat = accept & (bus.snk_adr == 2'b00);
    assign pop       = {1'b0, bus.snk_sel[0]} + {1'b0, bus.snk_sel[1]};
    assign seed      = ((bus.snk_dat ^ 16'hACE1) == 16'd0) ? 16'hACE1 : (bus.snk_dat ^ 16'hACE1);

    always_comb begin
        state_nxt = state;
        hdr_beat  = 1'b0;
        seq_beat  = 1'b0;
        pl_beat   = 1'b0;
        eval      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt = S_HDR;
                    hdr_beat  = data_beat;
                end
            end
            S_HDR: begin
                hdr_beat = data_beat;
                if (fall)                             state_nxt = S_EVAL;
                else if (data_beat && hdr_cnt == 3'd6) state_nxt = S_SEQ;
            end
            S_SEQ: begin
                seq_beat = data_beat;
                if (fall)           state_nxt = S_EVAL;
                else if (data_beat) state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                pl_beat = data_beat;
                if (fall) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                eval      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mism    = (bus.snk_sel[0] && bus.snk_dat[7:0]  != lfsr_q[7:0]) ||
                     (bus.snk_sel[1] && bus.snk_dat[15:8] != lfsr_q[15:8]);
    assign len_err = ~reached_pl | (byte_cnt != {16'd0, len_q});

    assign wb_req  = bus.wb_cyc & bus.wb_stb;
    assign wr_ctrl = wb_req & bus.wb_we & (bus.wb_adr[4:2] == 3'd0);
    assign clr     = wr_ctrl & bus.wb_dat_i[1];
    assign en_rise = wr_ctrl & bus.wb_dat_i[0] & ~enable;

    always_ff @(posedge clk_i) begin
        cyc_q <= bus.snk_cyc;
        if (!rst_n_i) begin
            state   <= S_IDLE;
            bus.snk_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            bus.snk_ack <= accept;
        end
    end

    // Per-frame datapath; frame_en snapshots ENABLE at the start of the frame.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hdr_cnt    <= 3'd0;
            len_q      <= 16'd0;
            seq_q      <= 16'd0;
            lfsr_q     <= 16'd0;
            byte_cnt   <= 32'd0;
            data_err   <= 1'b0;
            reached_pl <= 1'b0;
            frame_en   <= 1'b0;
        end else begin
            if (state == S_IDLE && rise) begin
                hdr_cnt    <= data_beat ? 3'd1 : 3'd0;
                byte_cnt   <= 32'd0;
                data_err   <= 1'b0;
                reached_pl <= 1'b0;
                frame_en   <= enable;
            end else if (hdr_beat) begin
                hdr_cnt <= hdr_cnt + 3'd1;
                if (hdr_cnt == 3'd6) len_q <= bus.snk_dat;
            end else if (seq_beat) begin
                seq_q      <= bus.snk_dat;
                lfsr_q     <= seed;
                byte_cnt   <= byte_cnt + {30'd0, pop};
                reached_pl <= 1'b1;
            end else if (pl_beat) begin
                if (mism) data_err <= 1'b1;
                lfsr_q   <= lfsr_next(lfsr_q);
                byte_cnt <= byte_cnt + {30'd0, pop};
            end
            if (clr) frame_en <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            enable    <= 1'b0;
            seq_armed <= 1'b0;
            exp_seq   <= 16'd0;
            last_seq  <= 16'd0;
            cnt_ok    <= 32'd0;
            cnt_len   <= 32'd0;
            cnt_data  <= 32'd0;
            cnt_lost  <= 32'd0;
        end else begin
            if (wr_ctrl) enable <= bus.wb_dat_i[0];
            if (clr) begin
                cnt_ok    <= 32'd0;
                cnt_len   <= 32'd0;
                cnt_data  <= 32'd0;
                cnt_lost  <= 32'd0;
                seq_armed <= 1'b0;
            end else begin
                if (eval && frame_en) begin
                    if (len_err)       cnt_len  <= sat_inc(cnt_len);
                    else if (data_err) cnt_data <= sat_inc(cnt_data);
                    else               cnt_ok   <= sat_inc(cnt_ok);
                    if (reached_pl) begin
                        if (seq_armed && seq_q != exp_seq)
                            cnt_lost <= sat_add(cnt_lost, seq_q - exp_seq);
                        last_seq  <= seq_q;
                        exp_seq   <= seq_q + 16'd1;
                        seq_armed <= 1'b1;
                    end
                end
                if (en_rise) seq_armed <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (bus.wb_adr[4:2])
            3'd0: rd_mux = {31'd0, enable};
            3'd1: rd_mux = cnt_ok;
            3'd2: rd_mux = cnt_len;
            3'd3: rd_mux = cnt_data;
            3'd4: rd_mux = cnt_lost;
            3'd5: rd_mux = {16'd0, last_seq};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bus.wb_ack   <= 1'b0;
            bus.wb_dat_o <= 32'd0;
        end else begin
            bus.wb_ack   <= wb_req;
            bus.wb_dat_o <= wb_req ? rd_mux : 32'd0;
        end
    end

    assign bus.wb_stall = 1'b0;

`ifdef WRF_CHK_RAND_STALL_EN
    logic [15:0] stall_lfsr;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) stall_lfsr <= 16'hACE1;
        else          stall_lfsr <= lfsr_next(stall_lfsr);
    end
    assign bus.snk_stall = stall_lfsr[0];
`else
    assign bus.snk_stall = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{bus.snk_we, bus.wb_sel, bus.wb_adr[31:5], bus.wb_adr[1:0], bus.wb_dat_i[31:2]};

endmodule

// File: tb/tb_wrf_pkt_checker.sv
// Directed bench for wrf_pkt_checker: table of frame/control steps with expected counters, plus CLEAR corner sequences.
module tb_wrf_pkt_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wrf_pkt_checker_if b();
    wrf_pkt_checker dut (.clk_i(clk), .rst_n_i(rst_n), .bus(b.slave));

    int n_chk = 0;
    int n_pass = 0;

    localparam int OP_FRAME = 0;
    localparam int OP_CLEAR = 1;
    localparam int OP_CTRL  = 2;

    typedef struct {
        int          op;
        logic [15:0] seq;
        int          len;
        int          nb;
        int          hw;
        int          cor;
        bit          oob;
        logic [31:0] e_ok, e_len, e_data, e_lost, e_last;
    } vec_t;

    localparam int NV = 27;
    vec_t vt[NV];

    function automatic vec_t mk(input int op, input logic [15:0] seq, input int len, input int nb,
                                input int hw, input int cor, input bit oob,
                                input logic [31:0] ok, el, ed, lo, la);
        vec_t v;
        v.op = op; v.seq = seq; v.len = len; v.nb = nb; v.hw = hw; v.cor = cor; v.oob = oob;
        v.e_ok = ok; v.e_len = el; v.e_data = ed; v.e_lost = lo; v.e_last = la;
        return v;
    endfunction

    function automatic logic [15:0] nx(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] seed_of(input logic [15:0] s);
        logic [15:0] x;
        x = s ^ 16'hACE1;
        return (x == 16'd0) ? 16'hACE1 : x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Fabric ack monitor: every accepted beat must be acked exactly one cycle later.
    bit prev_acc = 1'b0;
    int ack_err = 0, n_acc = 0, n_ack = 0, stall_seen = 0;
    always @(negedge clk) begin
        if (!rst_n) prev_acc = 1'b0;
        else begin
            if (b.snk_ack !== prev_acc) ack_err++;
            if (b.snk_ack === 1'b1) n_ack++;
            prev_acc = (b.snk_cyc & b.snk_stb & ~b.snk_stall) === 1'b1;
            if (prev_acc) n_acc++;
        end
        if (b.snk_stall === 1'b1) stall_seen++;
    end

    task automatic beat(input logic [1:0] adr, input logic [1:0] sel, input logic [15:0] d);
        bit acc;
        int t;
        b.snk_cyc = 1'b1; b.snk_stb = 1'b1; b.snk_we = 1'b1;
        b.snk_adr = adr; b.snk_sel = sel; b.snk_dat = d;
        acc = 1'b0; t = 0;
        while (!acc && t < 64) begin
            @(negedge clk); acc = (b.snk_stall === 1'b0);
            @(posedge clk); #1;
            t++;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL beat_timeout: stall held for %0d cycles, required acceptance", t);
        end
        b.snk_stb = 1'b0;
    endtask

    task automatic end_frame();
        b.snk_cyc = 1'b0; b.snk_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_body(input logic [15:0] seq, input int nb, input int cor);
        int rem, k;
        logic [15:0] l, d;
        logic [1:0] s;
        rem = nb;
        if (rem > 0) begin
            beat(2'b00, (rem >= 2) ? 2'b11 : 2'b01, seq);
            rem -= (rem >= 2) ? 2 : 1;
        end
        l = seed_of(seq); k = 1;
        while (rem > 0) begin
            s = (rem >= 2) ? 2'b11 : 2'b01;
            d = l ^ ((k == cor) ? 16'h0001 : 16'h0000);
            if (s == 2'b01) d[15:8] = 8'h5A;
            beat(2'b00, s, d);
            rem -= (rem >= 2) ? 2 : 1;
            l = nx(l); k++;
        end
    endtask

    // Returns one cycle after cyc falls, i.e. in the checker's EVAL cycle.
    task automatic send_frame(input logic [15:0] seq, input int len, input int nb,
                              input int hw, input int cor, input bit oob);
        for (int h = 0; h < hw; h++)
            beat(2'b00, 2'b11, (h == 6) ? len[15:0] : 16'h1000 + h[15:0]);
        if (oob) begin
            beat(2'b01, 2'b11, 16'hDEAD);
            beat(2'b11, 2'b11, 16'hBEEF);
        end
        if (hw == 7) send_body(seq, nb, cor);
        end_frame();
    endtask

    task automatic reg_write(input logic [2:0] idx, input logic [31:0] d);
        b.wb_cyc = 1'b1; b.wb_stb = 1'b1; b.wb_we = 1'b1;
        b.wb_adr = {27'd0, idx, 2'b00}; b.wb_dat_i = d;
        @(posedge clk); #1;
        b.wb_cyc = 1'b0; b.wb_stb = 1'b0; b.wb_we = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] idx, output logic [31:0] d);
        b.wb_cyc = 1'b1; b.wb_stb = 1'b1; b.wb_we = 1'b0;
        b.wb_adr = {27'd0, idx, 2'b00};
        @(posedge clk); #1;
        chk("wb_ack", {31'd0, b.wb_ack}, 32'd1);
        d = b.wb_dat_o;
        b.wb_cyc = 1'b0; b.wb_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] ok, el, ed, lo, la);
        logic [31:0] r;
        reg_read(3'd1, r); chk({tag, "_ok"},   r, ok);
        reg_read(3'd2, r); chk({tag, "_len"},  r, el);
        reg_read(3'd3, r); chk({tag, "_data"}, r, ed);
        reg_read(3'd4, r); chk({tag, "_lost"}, r, lo);
        reg_read(3'd5, r); chk({tag, "_last"}, r, la);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;

        for (int i = 0; i < 10; i++)
            vt[i] = mk(OP_FRAME, i[15:0], 100, 100, 7, -1, 0, i + 1, 0, 0, 0, i);
        vt[10] = mk(OP_CLEAR, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 9);
        vt[11] = mk(OP_FRAME, 0, 100, 100, 7, -1, 0, 1, 0, 0, 0, 0);
        vt[12] = mk(OP_FRAME, 5, 100, 100, 7, -1, 0, 2, 0, 0, 4, 5);
        vt[13] = mk(OP_CLEAR, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 5);
        vt[14] = mk(OP_FRAME, 6, 200, 198, 7, -1, 0, 0, 1, 0, 0, 6);
        vt[15] = mk(OP_FRAME, 0, 0, 0, 3, -1, 0, 0, 2, 0, 0, 6);
        vt[16] = mk(OP_FRAME, 7, 100, 100, 7, 10, 0, 0, 2, 1, 0, 7);
        vt[17] = mk(OP_FRAME, 8, 51, 51, 7, -1, 1, 1, 2, 1, 0, 8);
        vt[18] = mk(OP_CTRL, 0, 0, 0, 0, -1, 0, 1, 2, 1, 0, 8);
        vt[19] = mk(OP_FRAME, 100, 100, 100, 7, -1, 0, 1, 2, 1, 0, 8);
        vt[20] = mk(OP_CTRL, 1, 0, 0, 0, -1, 0, 1, 2, 1, 0, 8);
        vt[21] = mk(OP_FRAME, 200, 100, 100, 7, -1, 0, 2, 2, 1, 0, 200);
        vt[22] = mk(OP_FRAME, 16'hFFFF, 20, 20, 7, -1, 0, 3, 2, 1, 65334, 16'hFFFF);
        vt[23] = mk(OP_FRAME, 0, 20, 20, 7, -1, 0, 4, 2, 1, 65334, 0);
        vt[24] = mk(OP_FRAME, 16'hACE1, 30, 30, 7, -1, 0, 5, 2, 1, 109590, 16'hACE1);
        vt[25] = mk(OP_FRAME, 0, 0, 0, 7, -1, 0, 5, 3, 1, 109590, 16'hACE1);
        vt[26] = mk(OP_FRAME, 16'hACE2, 2, 2, 7, -1, 0, 6, 3, 1, 109590, 16'hACE2);

        b.snk_cyc = 0; b.snk_stb = 0; b.snk_we = 0; b.snk_sel = 0; b.snk_adr = 0; b.snk_dat = 0;
        b.wb_cyc = 1; b.wb_stb = 1; b.wb_we = 0; b.wb_sel = 4'hF; b.wb_adr = 32'h4; b.wb_dat_i = 0;

        // Strobe held during reset: acks and read data must stay zero.
        repeat (4) @(posedge clk);
        #1;
        chk("rst_snk_ack", {31'd0, b.snk_ack}, 32'd0);
        chk("rst_wb_ack",  {31'd0, b.wb_ack},  32'd0);
        chk("rst_wb_dat",  b.wb_dat_o,         32'd0);
        b.wb_cyc = 0; b.wb_stb = 0;
        rst_n = 1'b1;
        idle(2);
        reg_read(3'd0, r); chk("rst_ctrl", r, 32'd0);
        check_regs("rst", 0, 0, 0, 0, 0);
        reg_read(3'd6, r); chk("rd_unmapped", r, 32'd0);

        reg_write(3'd0, 32'd1);
        reg_read(3'd0, r); chk("ctrl_enable", r, 32'd1);

        for (int i = 0; i < NV; i++) begin
            case (vt[i].op)
                OP_FRAME: send_frame(vt[i].seq, vt[i].len, vt[i].nb, vt[i].hw, vt[i].cor, vt[i].oob);
                OP_CLEAR: reg_write(3'd0, 32'd3);
                default:  reg_write(3'd0, {16'd0, vt[i].seq});
            endcase
            idle(2);
            check_regs($sformatf("v%0d", i), vt[i].e_ok, vt[i].e_len, vt[i].e_data, vt[i].e_lost, vt[i].e_last);
        end

        // CLEAR in the middle of a frame: frame is ignored, counters zero, tracking re-armed.
        for (int h = 0; h < 7; h++) beat(2'b00, 2'b11, (h == 6) ? 16'd100 : 16'h2000);
        send_body(16'd300, 12, -1);
        b.snk_stb = 1'b0;
        reg_write(3'd0, 32'd3);
        beat(2'b00, 2'b11, 16'h0BAD);
        beat(2'b00, 2'b11, 16'h0BAD);
        end_frame();
        idle(2);
        check_regs("midclr", 0, 0, 0, 0, 16'hACE2);
        send_frame(16'd42, 100, 100, 7, -1, 0);
        idle(2);
        check_regs("seq42", 1, 0, 0, 0, 42);

        // CLEAR landing in the EVAL cycle must win over the OK increment.
        send_frame(16'd43, 100, 100, 7, -1, 0);
        reg_write(3'd0, 32'd3);
        idle(2);
        reg_read(3'd1, r); chk("evclr_ok", r, 32'd0);
        reg_read(3'd2, r); chk("evclr_len", r, 32'd0);
        reg_read(3'd4, r); chk("evclr_lost", r, 32'd0);
        send_frame(16'd1000, 100, 100, 7, -1, 0);
        idle(2);
        check_regs("rearm", 1, 0, 0, 0, 1000);

`ifdef WRF_CHK_RAND_STALL_EN
        reg_write(3'd0, 32'd3);
        for (int i = 0; i < 1000; i++) begin
            send_frame(i[15:0], 4, 4, 7, -1, 0);
            idle(1);
        end
        idle(2);
        check_regs("rand", 1000, 0, 0, 0, 999);
        chk("stall_active", {31'd0, stall_seen != 0}, 32'd1);
`else
        chk("stall_zero", stall_seen, 32'd0);
`endif

        idle(4);
        chk("ack_timing_errs", ack_err, 32'd0);
        chk("ack_count", n_ack, n_acc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
